// File: rtl/ntt_rr_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ntt_rr_arbiter_pkg
// Description : Shared KEM types for the NTT scheduling path. Holds the
//               wrapper mode encoding, the default watchdog budget and the
//               helper that says which modes the NTT wrapper can execute.
// Revision    : 1.0 - initial release
// ============================================================================
package ntt_rr_arbiter_pkg;

  // Operation codes understood by the polynomial datapath. The shared NTT
  // wrapper implements only the forward transform and the pointwise
  // multiply; the remaining encodings are reserved for other engines.
  typedef enum logic [1:0] {
    NTT_a  = 2'd0,
    PWM_ab = 2'd1,
    INTT_a = 2'd2,
    RSVD_3 = 2'd3
  } ntt_mode_t;

  // A full wrapper NTT job takes about 1.1k cycles; this leaves ample margin
  // before the watchdog gives up on a stuck wrapper.
  localparam int NTT_TIMEOUT_CYCLES = 4095;

  // True when the wrapper can execute the requested mode.
  function automatic logic ntt_mode_legal(input ntt_mode_t mode);
    return (mode == NTT_a) || (mode == PWM_ab);
  endfunction

endpackage : ntt_rr_arbiter_pkg
`default_nettype wire

// File: rtl/ntt_rr_arbiter_rr_prio_enc.sv
`default_nettype none
// ============================================================================
// Module      : rr_prio_enc
// Description : Circular priority encoder. Finds the first asserted request
//               at or after the pointer position, wrapping past N_REQ-1.
// Ports       : req   - request vector
//               ptr   - position that has highest priority (0..N_REQ-1)
//               valid - at least one request is asserted
//               idx   - index of the winning request (0 when none)
// Revision    : 1.0 - initial release
// ============================================================================
module rr_prio_enc #(
  parameter int N_REQ = 3,
  parameter int SEL_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  output logic             valid,
  output logic [SEL_W-1:0] idx
);

  // ptr + offset never exceeds 2*N_REQ-2, so one conditional subtract wraps.
  function automatic int wrap(input int pos);
    return (pos >= N_REQ) ? pos - N_REQ : pos;
  endfunction

  logic [SEL_W-1:0] w_pos;

  always_comb begin
    valid = |req;
    idx   = '0;
    w_pos = '0;
    // Walk from the farthest offset back to the pointer itself so the
    // closest asserted request is the last one written.
    for (int off = N_REQ - 1; off >= 0; off--) begin
      w_pos = SEL_W'(wrap(int'(ptr) + off));
      if (req[w_pos]) begin
        idx = w_pos;
      end
    end
  end

endmodule : rr_prio_enc
`default_nettype wire

// File: rtl/ntt_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ntt_rr_arbiter
// Description : Round-robin scheduler sharing one NTT wrapper between N_REQ
//               sequencers. Grants one job at a time, pulses the wrapper run
//               input with the granted mode, steers the operand mux, returns
//               a per-requester completion pulse, aborts jobs that exceed the
//               watchdog budget and rejects modes the wrapper cannot run.
// Ports       : clk_i, rst_n_i  - clock, asynchronous active-low reset
//               req_i / mode_i  - per-requester job request and mode
//               ack_o / done_o  - one-hot accept / finish pulses
//               ntt_run_o, ntt_mode_o, ntt_sel_o - wrapper control
//               ntt_done_i      - wrapper completion
//               busy_o, err_timeout_o, err_mode_o - status (errors sticky)
// Revision    : 1.0 - initial release
// ============================================================================
module ntt_rr_arbiter
  import ntt_rr_arbiter_pkg::*;
#(
  parameter int N_REQ   = 3,
  parameter int TIMEOUT = NTT_TIMEOUT_CYCLES,
  parameter int SEL_W   = $clog2(N_REQ)
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [N_REQ-1:0] req_i,
  input  ntt_mode_t        mode_i [N_REQ],
  output logic [N_REQ-1:0] ack_o,
  output logic [N_REQ-1:0] done_o,
  output logic             ntt_run_o,
  output ntt_mode_t        ntt_mode_o,
  output logic [SEL_W-1:0] ntt_sel_o,
  input  logic             ntt_done_i,
  output logic             busy_o,
  output logic             err_timeout_o,
  output logic             err_mode_o
);

  // The watchdog only has to count up to TIMEOUT-1 before firing.
  localparam int             WD_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(N_REQ - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_FIN   = 2'd3
  } state_t;

  function automatic logic [N_REQ-1:0] grant_vec(input logic [SEL_W-1:0] idx);
    logic [N_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  state_t           r_state;
  logic [N_REQ-1:0] r_req;
  logic [SEL_W-1:0] r_ptr;
  logic [SEL_W-1:0] r_grant;
  ntt_mode_t        r_mode;
  logic [WD_W-1:0]  r_wd;
  logic [N_REQ-1:0] r_ack;
  logic [N_REQ-1:0] r_done;
  logic             r_run;
  logic             r_busy;
  logic             r_err_to;
  logic             r_err_mode;

  // Next-state values
  state_t           w_state;
  logic [SEL_W-1:0] w_ptr;
  logic [SEL_W-1:0] w_grant;
  ntt_mode_t        w_mode;
  logic [WD_W-1:0]  w_wd;
  logic [N_REQ-1:0] w_ack;
  logic [N_REQ-1:0] w_done;
  logic             w_run;
  logic             w_busy;
  logic             w_err_to;
  logic             w_err_mode;

  logic             w_req_valid;
  logic [SEL_W-1:0] w_req_idx;

  // Arbitration works on the captured request vector, so a request that
  // rises in cycle t is granted at the end of t+1 and acknowledged in t+2.
  rr_prio_enc #(
    .N_REQ (N_REQ),
    .SEL_W (SEL_W)
  ) u_prio_enc (
    .req   (r_req),
    .ptr   (r_ptr),
    .valid (w_req_valid),
    .idx   (w_req_idx)
  );

  // --------------------------------------------------------------------------
  // Next-state and output decode
  // --------------------------------------------------------------------------
  always_comb begin
    w_state    = r_state;
    w_ptr      = r_ptr;
    w_grant    = r_grant;
    w_mode     = r_mode;
    w_wd       = r_wd;
    w_ack      = '0;
    w_done     = '0;
    w_run      = 1'b0;
    w_err_to   = r_err_to;
    w_err_mode = r_err_mode;

    case (r_state)
      S_IDLE: begin
        if (w_req_valid) begin
          // Grant, mode and mux select are latched together; the accept
          // pulse and (for a legal mode) the run pulse fill the ISSUE cycle.
          w_state = S_ISSUE;
          w_grant = w_req_idx;
          w_mode  = mode_i[w_req_idx];
          w_ack   = grant_vec(w_req_idx);
          w_run   = ntt_mode_legal(mode_i[w_req_idx]);
        end
      end

      S_ISSUE: begin
        w_wd = '0;
        if (ntt_mode_legal(r_mode)) begin
          w_state = S_WAIT;
        end else begin
          // Rejected job: finish immediately, wrapper never started.
          w_state    = S_FIN;
          w_err_mode = 1'b1;
          w_done     = grant_vec(r_grant);
        end
      end

      S_WAIT: begin
        // Completion is checked first so a done arriving on the watchdog's
        // final cycle still counts as a normal finish.
        if (ntt_done_i) begin
          w_state = S_FIN;
          w_done  = grant_vec(r_grant);
        end else if (r_wd == WD_LAST) begin
          w_state  = S_FIN;
          w_err_to = 1'b1;
          w_done   = grant_vec(r_grant);
        end else begin
          w_wd = r_wd + WD_W'(1);
        end
      end

      S_FIN: begin
        w_state = S_IDLE;
        w_wd    = '0;
        w_ptr   = (r_grant == SEL_LAST) ? '0 : r_grant + SEL_W'(1);
      end

      default: begin
        w_state = S_IDLE;
      end
    endcase
  end

  assign w_busy = (w_state != S_IDLE);

  // --------------------------------------------------------------------------
  // State and registered outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state    <= S_IDLE;
      r_req      <= '0;
      r_ptr      <= '0;
      r_grant    <= '0;
      r_mode     <= NTT_a;
      r_wd       <= '0;
      r_ack      <= '0;
      r_done     <= '0;
      r_run      <= 1'b0;
      r_busy     <= 1'b0;
      r_err_to   <= 1'b0;
      r_err_mode <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_req      <= req_i;
      r_ptr      <= w_ptr;
      r_grant    <= w_grant;
      r_mode     <= w_mode;
      r_wd       <= w_wd;
      r_ack      <= w_ack;
      r_done     <= w_done;
      r_run      <= w_run;
      r_busy     <= w_busy;
      r_err_to   <= w_err_to;
      r_err_mode <= w_err_mode;
    end
  end

  assign ack_o         = r_ack;
  assign done_o        = r_done;
  assign ntt_run_o     = r_run;
  assign ntt_mode_o    = r_mode;
  assign ntt_sel_o     = r_grant;
  assign busy_o        = r_busy;
  assign err_timeout_o = r_err_to;
  assign err_mode_o    = r_err_mode;

endmodule : ntt_rr_arbiter
`default_nettype wire
